// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame states, prefix bytes and the set 2 to HID usage map
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_F     = 8'h09;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_J     = 8'h0D;
    localparam logic [7:0] HID_K     = 8'h0E;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_ESC   = 8'h29;
    function automatic logic [7:0] set2_to_hid(input logic [7:0] code);
        case (code)
            8'h23:   return HID_D;
            8'h2B:   return HID_F;
            8'h29:   return HID_SPACE;
            8'h3B:   return HID_J;
            8'h42:   return HID_K;
            8'h5A:   return HID_ENTER;
            8'h76:   return HID_ESC;
            default: return 8'h00;
        endcase
    endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes and filters the PS/2 lines, frames 11-bit words and flags parity, stop and timeout errors
module ps2_frame_rx import ps2_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_stb,
    output logic       err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [SYNC_STAGES-1:0] cs, ds;
    logic          filt, filt_d, fall, d, tmo, par, par_n, stb_n, err_n, err_q;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    sh, sh_n;
    frame_state_t  state, state_n;
    assign d   = ds[SYNC_STAGES-1];
    assign err = err_q | tmo;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cs        <= '1;
            ds        <= '1;
            filt      <= 1'b1;
            filt_d    <= 1'b1;
            fall      <= 1'b0;
            fcnt      <= '0;
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            sh        <= 8'h00;
            par       <= 1'b0;
            tcnt      <= '0;
            data_byte <= 8'h00;
            byte_stb  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cs        <= {cs[SYNC_STAGES-2:0], ps2_clk};
            ds        <= {ds[SYNC_STAGES-2:0], ps2_data};
            // the filtered clock only follows after FILTER_LEN agreeing samples
            fcnt      <= (cs[SYNC_STAGES-1] == filt || fcnt == FW'(FILTER_LEN - 1)) ? '0 : fcnt + 1'b1;
            filt      <= (cs[SYNC_STAGES-1] != filt && fcnt == FW'(FILTER_LEN - 1)) ? cs[SYNC_STAGES-1] : filt;
            filt_d    <= filt;
            fall      <= filt_d & ~filt;
            state     <= state_n;
            bit_cnt   <= bit_n;
            sh        <= sh_n;
            par       <= par_n;
            tcnt      <= tcnt_n;
            data_byte <= stb_n ? sh : data_byte;
            byte_stb  <= stb_n;
            err_q     <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        sh_n    = sh;
        par_n   = par;
        stb_n   = 1'b0;
        err_n   = 1'b0;
        tmo     = state != IDLE && tcnt == TW'(TIMEOUT_CYC);
        tcnt_n  = (state == IDLE || fall || tmo) ? '0 : tcnt + 1'b1;
        if (tmo)
            state_n = IDLE;
        else if (fall)
            case (state)
                IDLE: begin
                    state_n = d ? IDLE : DATA;
                    bit_n   = 3'd0;
                end
                DATA: begin
                    sh_n    = {d, sh[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    state_n = bit_cnt == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = d;
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    stb_n   = d & ^{sh, par};
                    err_n   = ~(d & ^{sh, par});
                end
            endcase
    end
endmodule

// File: rtl/ps2_keycode.sv
// ps2_keycode: tracks E0/F0 prefixes on received set 2 bytes and holds the HID usage of the last pressed mapped key
module ps2_keycode import ps2_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic [7:0] scancode,
    output logic       scancode_stb,
    output logic       frame_err
);
    logic       ext, brk, is_code;
    logic [7:0] hid;
    ps2_frame_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_byte(scancode),
        .byte_stb (scancode_stb),
        .err      (frame_err)
    );
    assign hid       = set2_to_hid(scancode);
    assign is_code   = scancode != PS2_EXT && scancode != PS2_BRK;
    assign key_valid = keycode != 8'h00;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            keycode <= 8'h00;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (scancode_stb) begin
            ext <= scancode == PS2_EXT ? 1'b1 : (scancode == PS2_BRK ? ext : 1'b0);
            brk <= scancode == PS2_BRK ? 1'b1 : (scancode == PS2_EXT ? brk : 1'b0);
            // a break only releases the key currently shown, so an older key's release is ignored
            if (is_code && !ext && hid != 8'h00)
                keycode <= brk ? (hid == keycode ? 8'h00 : keycode) : hid;
        end
    end
endmodule
